// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: FSM encodings and default operand width shared by the adder family
package serial_add_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder_1b.sv
// full_adder_1b: one-bit full adder built from two half adders and an OR gate
// Ports: a, b, ci - addend bits and carry-in; s - sum bit; co - carry-out
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_s1, w_c1, w_c2;
    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;
    assign co   = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, one bit per clock through a single full adder
// Ports: clk, rst (async, active-high); start, a, b - request and operands (captured on accept);
//        busy - high in RUN; done - one-cycle pulse in DONE; sum, carry - registered result of a+b
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_s, r_sum;
    logic [CW-1:0] r_cnt;
    logic r_c, r_carry, w_bit, w_co, w_last;
    full_adder_1b u_fa (.a(r_a[0]), .b(r_b[0]), .ci(r_c), .s(w_bit), .co(w_co));
    assign w_last = r_cnt == LAST;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_a   <= a;
                r_b   <= b;
                r_s   <= '0;
                r_c   <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_s   <= {w_bit, r_s[WIDTH-1:1]};
                r_c   <= w_co;
                r_cnt <= r_cnt + CW'(1);
                // publish only the complete word so partial results never show on sum
                if (w_last) begin
                    r_sum   <= {w_bit, r_s[WIDTH-1:1]};
                    r_carry <= w_co;
                end
            end
        end
    end
    assign busy  = r_state == RUN;
    assign done  = r_state == DONE;
    assign sum   = r_sum;
    assign carry = r_carry;
endmodule
